cr_xp10_decomp_be_omux: RTL and testbench

CR_XP10_DECOMP_BE_OMUX -- requirements
Module: cr_xp10_decomp_be_omux

---
 rtl/cr_xp10_decomp_be_omux_if.sv | 37 +++
 rtl/cr_xp10_decomp_be_omux.sv | 186 ++++++++++++++++++
 tb/tb_cr_xp10_decomp_be_omux.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_xp10_decomp_be_omux_if.sv
`default_nettype none
// ============================================================================
// Module      : cr_xp10_decomp_be_omux_if
// Description : TLV input channels and the merged output beat stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface cr_xp10_decomp_be_omux_if #(
    parameter int N_CH = 2,
    parameter int DW   = 64,
    parameter int BW   = $clog2(DW/8) + 1,
    parameter int CHW  = $clog2(N_CH)
);
    logic [N_CH-1:0]    in_valid;
    logic [N_CH*DW-1:0] in_data;
    logic [N_CH*BW-1:0] in_bytes;
    logic [N_CH-1:0]    in_last;
    logic [N_CH-1:0]    in_ready;

    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic [BW-1:0]      out_bytes;
    logic               out_last;
    logic               out_err;
    logic [CHW-1:0]     out_ch;
    logic               out_ready;

    // master: source/sink environment; slave: the output mux
    modport master (
        output in_valid, in_data, in_bytes, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_bytes, out_last, out_err, out_ch
    );
    modport slave (
        input  in_valid, in_data, in_bytes, in_last, out_ready,
        output in_ready, out_valid, out_data, out_bytes, out_last, out_err, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/cr_xp10_decomp_be_omux.sv
`default_nettype none
// ============================================================================
// Module      : cr_xp10_decomp_be_omux
// Description : Frame-granular round-robin mux of TLV channels into a FWFT
//               output FIFO, with optional per-frame output byte limit.
// Revision    : 1.0 - initial release
// ============================================================================
module cr_xp10_decomp_be_omux #(
    parameter int N_CH  = 2,
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int BW    = $clog2(DW/8) + 1
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    cr_xp10_decomp_be_omux_if.slave      bus,
    input  wire logic                    sw_olimit_en,
    input  wire logic [23:0]             sw_olimit,
    output logic                         olimit_err,
    output logic [$clog2(N_CH)-1:0]      olimit_err_ch,
    output logic                         busy
);
    localparam int c_chw = $clog2(N_CH);
    localparam int c_aw  = $clog2(DEPTH);
    localparam int c_cw  = $clog2(DEPTH + 1);
    localparam int c_ew  = DW + BW + 2 + c_chw;
    localparam logic [c_chw:0] c_n_ch = (c_chw + 1)'(N_CH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_chw-1:0]   r_rr, r_grant;
    logic [23:0]        r_cnt, r_lim;
    logic               r_lim_en;
    logic               r_err;
    logic [c_chw-1:0]   r_err_ch;

    logic [c_ew-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0]    r_wptr, r_rptr;
    logic [c_cw-1:0]    r_count;

    logic [2*N_CH-1:0]  w_dbl, w_sh;
    logic [N_CH-1:0]    w_rot;
    logic               w_found;
    logic [c_chw-1:0]   w_off, w_pick, w_rr_nxt;
    logic [c_chw:0]     w_psum, w_ginc;

    logic               w_vld, w_last;
    logic [DW-1:0]      w_data;
    logic [BW-1:0]      w_bytes;
    logic [N_CH-1:0]    w_rdy;
    logic               w_full, w_acc, w_push, w_pop, w_ovalid, w_show, w_trunc, w_frame_end;
    logic [24:0]        w_sum;
    logic [c_ew-1:0]    w_head;

    // Rotate valids so bit 0 is the channel at rr_ptr; the lowest set bit wins.
    assign w_dbl = {bus.in_valid, bus.in_valid};
    assign w_sh  = w_dbl >> r_rr;
    assign w_rot = w_sh[N_CH-1:0];

    always_comb begin
        w_off = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = c_chw'(k);
        end
    end

    assign w_found = |w_rot;
    assign w_psum  = {1'b0, r_rr} + {1'b0, w_off};
    assign w_pick  = (w_psum >= c_n_ch) ? c_chw'(w_psum - c_n_ch) : w_psum[c_chw-1:0];
    assign w_ginc  = {1'b0, r_grant} + (c_chw + 1)'(1);
    assign w_rr_nxt = (w_ginc == c_n_ch) ? '0 : w_ginc[c_chw-1:0];

    always_comb begin
        w_vld   = 1'b0;
        w_data  = '0;
        w_bytes = '0;
        w_last  = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_grant == c_chw'(k)) begin
                w_vld   = bus.in_valid[k];
                w_data  = bus.in_data[k*DW +: DW];
                w_bytes = bus.in_bytes[k*BW +: BW];
                w_last  = bus.in_last[k];
            end
        end
    end

    assign w_full = (r_count == c_cw'(DEPTH));

    always_comb begin
        w_rdy = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_rdy[i] = !rst && (r_state != IDLE) && (r_grant == c_chw'(i)) &&
                       ((r_state == DRAIN) || !w_full);
        end
    end
    assign bus.in_ready = w_rdy;

    assign w_acc       = w_vld && (r_state != IDLE) && ((r_state == DRAIN) || !w_full);
    assign w_push      = w_acc && (r_state == LOCK);
    assign w_sum       = {1'b0, r_cnt} + {{(25 - BW){1'b0}}, w_bytes};
    assign w_trunc     = r_lim_en && (w_sum > {1'b0, r_lim});
    assign w_frame_end = w_acc && w_last;
    assign w_ovalid    = (r_count != '0);
    assign w_pop       = w_ovalid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_found) w_state_nxt = LOCK;
            LOCK: begin
                if (w_acc && w_trunc) w_state_nxt = w_last ? IDLE : DRAIN;
                else if (w_acc && w_last) w_state_nxt = IDLE;
            end
            DRAIN: if (w_acc && w_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr     <= '0;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_lim    <= '0;
            r_lim_en <= 1'b0;
            r_err    <= 1'b0;
            r_err_ch <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_err <= w_push && w_trunc;
            if (w_push && w_trunc) r_err_ch <= r_grant;

            // Limit controls are frozen at grant so software changes never split a frame.
            if (r_state == IDLE && w_found) begin
                r_grant  <= w_pick;
                r_cnt    <= '0;
                r_lim_en <= sw_olimit_en;
                r_lim    <= sw_olimit;
            end else if (w_push) begin
                r_cnt <= w_sum[24] ? 24'hFF_FFFF : w_sum[23:0];
            end

            if (w_frame_end) r_rr <= w_rr_nxt;

            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_data, w_bytes, (w_last | w_trunc), w_trunc, r_grant};
    end

    assign w_head = r_mem[r_rptr];
    assign w_show = !rst && w_ovalid;

    assign bus.out_valid = w_show;
    assign bus.out_data  = w_show ? w_head[c_ew-1 -: DW]    : '0;
    assign bus.out_bytes = w_show ? w_head[c_chw+2 +: BW]   : '0;
    assign bus.out_last  = w_show && w_head[c_chw+1];
    assign bus.out_err   = w_show && w_head[c_chw];
    assign bus.out_ch    = w_show ? w_head[c_chw-1:0]       : '0;

    assign olimit_err    = !rst && r_err;
    assign olimit_err_ch = rst ? '0 : r_err_ch;
    assign busy          = !rst && ((r_state != IDLE) || w_ovalid);
endmodule
`default_nettype wire

// File: tb/tb_cr_xp10_decomp_be_omux.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_xp10_decomp_be_omux
// Description : Directed bench with a frame-level scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr_xp10_decomp_be_omux;
    localparam int N_CH = 2;
    localparam int DW = 64;
    localparam int DEPTH = 4;
    localparam int BW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sw_olimit_en = 1'b0;
    logic [23:0] sw_olimit = '0;
    logic        olimit_err;
    logic [0:0]  olimit_err_ch;
    logic        busy;

    always #5 clk = ~clk;

    cr_xp10_decomp_be_omux_if #(.N_CH(N_CH), .DW(DW), .BW(BW)) ifc ();

    cr_xp10_decomp_be_omux #(.N_CH(N_CH), .DW(DW), .DEPTH(DEPTH), .BW(BW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (ifc),
        .sw_olimit_en  (sw_olimit_en),
        .sw_olimit     (sw_olimit),
        .olimit_err    (olimit_err),
        .olimit_err_ch (olimit_err_ch),
        .busy          (busy)
    );

    typedef struct { logic [DW-1:0] data; logic [BW-1:0] bytes; logic last; } beat_t;
    typedef struct { logic [DW-1:0] data; logic [BW-1:0] bytes; logic last; logic err; logic [0:0] ch; } obeat_t;

    beat_t  src [N_CH][$];
    obeat_t exp_q[$];
    int     exp_err[$];
    int     model_rr = 0;
    int     compared = 0;
    int     mismatched = 0;
    int     cyc = 0;
    int     first_ov = -1;
    int     err_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h, required %0h", nm, act, req);
        end
    endtask

    function automatic logic [DW-1:0] pat(int ch, int fid, int b);
        return {8'hA5, 8'(ch), 16'(fid), 16'(b), 16'hBEEF};
    endfunction

    task automatic add_beat(int ch, int fid, int b, int nbytes, bit last);
        beat_t x;
        x.data = pat(ch, fid, b);
        x.bytes = BW'(nbytes);
        x.last = last;
        src[ch].push_back(x);
    endtask

    task automatic add_frame(int ch, int fid, int n, int nbytes);
        for (int b = 0; b < n; b++) add_beat(ch, fid, b, nbytes, b == n - 1);
    endtask

    // Frame-level model: round-robin over channels with pending frames, then
    // forward beats until the limit is exceeded (that beat closes the frame).
    task automatic build_model(input bit en, input longint lim);
        int pos[N_CH];
        int ch;
        longint cnt, s;
        bit tr, more;
        beat_t b;
        obeat_t o;
        for (int c = 0; c < N_CH; c++) pos[c] = 0;
        more = 1;
        while (more) begin
            ch = -1;
            for (int k = N_CH - 1; k >= 0; k--)
                if (pos[(model_rr + k) % N_CH] < src[(model_rr + k) % N_CH].size()) ch = (model_rr + k) % N_CH;
            if (ch < 0) begin
                more = 0;
            end else begin
                cnt = 0;
                tr = 0;
                do begin
                    b = src[ch][pos[ch]];
                    pos[ch]++;
                    if (!tr) begin
                        s = cnt + longint'(b.bytes);
                        o.data = b.data; o.bytes = b.bytes; o.ch = 1'(ch);
                        if (en && s > lim) begin
                            o.last = 1; o.err = 1; tr = 1;
                            exp_err.push_back(ch);
                        end else begin
                            o.last = b.last; o.err = 0;
                            cnt = (s > 24'hFF_FFFF) ? 24'hFF_FFFF : s;
                        end
                        exp_q.push_back(o);
                    end
                end while (!b.last);
                model_rr = (ch + 1) % N_CH;
            end
        end
    endtask

    // Compare process: scoreboard pops, hold-while-stalled and limit pulses.
    initial begin : compare
        logic hold;
        logic [127:0] prev;
        obeat_t e;
        int ech;
        hold = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (ifc.out_valid && first_ov < 0) first_ov = cyc;
                if (hold)
                    chk("hold_stable", {ifc.out_valid, ifc.out_data, ifc.out_bytes, ifc.out_last, ifc.out_err, ifc.out_ch}, prev);
                hold = ifc.out_valid && !ifc.out_ready;
                prev = {ifc.out_valid, ifc.out_data, ifc.out_bytes, ifc.out_last, ifc.out_err, ifc.out_ch};
                if (ifc.out_valid && ifc.out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", ifc.out_data, '0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {ifc.out_data, ifc.out_bytes, ifc.out_last, ifc.out_err, ifc.out_ch},
                            {e.data, e.bytes, e.last, e.err, e.ch});
                    end
                end
                if (olimit_err) begin
                    err_pulses++;
                    ech = (exp_err.size() == 0) ? -1 : exp_err.pop_front();
                    chk("olimit_err_ch", 128'(olimit_err_ch), 128'(ech));
                end
            end
        end
    end

    task automatic clear_src();
        for (int c = 0; c < N_CH; c++) src[c].delete();
    endtask

    task automatic do_reset();
        rst = 1;
        ifc.in_valid = '0;
        ifc.out_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        model_rr = 0;
        exp_q.delete();
        exp_err.delete();
        clear_src();
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic run_test(input string nm, input int or_low, output int acc_win,
                            output bit rdy_end, output int first_acc);
        int sidx[N_CH];
        bit done;
        int n;
        logic [N_CH-1:0] v;
        done = 0; n = 0;
        acc_win = 0; rdy_end = 1; first_acc = -1;
        first_ov = -1; err_pulses = 0;
        for (int c = 0; c < N_CH; c++) sidx[c] = 0;
        while (!done && n < 600) begin
            ifc.out_ready = (n >= or_low);
            v = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (sidx[c] < src[c].size()) begin
                    v[c] = 1;
                    ifc.in_data[c*DW +: DW] = src[c][sidx[c]].data;
                    ifc.in_bytes[c*BW +: BW] = src[c][sidx[c]].bytes;
                    ifc.in_last[c] = src[c][sidx[c]].last;
                end
            end
            ifc.in_valid = v;
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) begin
                if (v[c] && ifc.in_ready[c]) begin
                    sidx[c]++;
                    if (first_acc < 0) first_acc = cyc;
                    if (n < or_low) acc_win++;
                end
            end
            if (n == or_low - 1) rdy_end = |ifc.in_ready;
            done = (exp_q.size() == 0) && !busy;
            for (int c = 0; c < N_CH; c++) if (sidx[c] < src[c].size()) done = 0;
            @(posedge clk);
            #1 n++;
        end
        ifc.in_valid = '0;
        ifc.out_ready = 1;
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: actual not drained, required drained within 600 cycles", nm);
        end
        chk({nm, "_leftover"}, 128'(exp_q.size()), 0);
    endtask

    initial begin
        int aw, fa, w;
        bit re;
        ifc.in_valid = '0;
        ifc.in_data = '0;
        ifc.in_bytes = '0;
        ifc.in_last = '0;
        ifc.out_ready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(ifc.in_ready), 0);
        chk("rst_out_valid", 128'(ifc.out_valid), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_olimit_err", {olimit_err, olimit_err_ch}, 0);
        chk("rst_out_fields", {ifc.out_data, ifc.out_bytes, ifc.out_last, ifc.out_err, ifc.out_ch}, 0);
        @(posedge clk);
        #1 rst = 0;

        // Single channel, three 8-byte beats.
        clear_src();
        add_frame(0, 1, 3, 8);
        build_model(0, 0);
        chk("t1_model_len", 128'(exp_q.size()), 3);
        chk("t1_model_last", {exp_q[0].last, exp_q[1].last, exp_q[2].last}, 3'b001);
        run_test("t1_single", 0, aw, re, fa);
        chk("t1_latency", 128'(first_ov), 128'(fa + 1));

        // Fairness: both channels continuously valid with 2-beat frames.
        do_reset();
        add_frame(0, 1, 2, 8); add_frame(0, 2, 2, 8);
        add_frame(1, 1, 2, 8); add_frame(1, 2, 2, 8);
        build_model(0, 0);
        chk("t2_model_order", {exp_q[0].ch, exp_q[2].ch, exp_q[4].ch, exp_q[6].ch}, 4'b0101);
        run_test("t2_fair", 0, aw, re, fa);

        // Backpressure: 10 stalled cycles on a long frame.
        clear_src();
        add_frame(0, 3, 8, 8);
        build_model(0, 0);
        run_test("t3_bp", 10, aw, re, fa);
        chk("t3_accepted_while_stalled", 128'(aw), 4);
        chk("t3_in_ready_low", 128'(re), 0);

        // Limit 20 on 4x8: third beat truncates, fourth dropped; next frame clean.
        sw_olimit_en = 1;
        sw_olimit = 24'd20;
        clear_src();
        add_frame(0, 4, 4, 8);
        add_beat(0, 5, 0, 8, 0); add_beat(0, 5, 1, 0, 0); add_beat(0, 5, 2, 8, 1);
        build_model(1, 20);
        chk("t4_model_len", 128'(exp_q.size()), 6);
        chk("t4_model_trunc", {exp_q[2].last, exp_q[2].err, exp_q[4].bytes, exp_q[5].err}, {2'b11, 4'd0, 1'b0});
        chk("t4_model_err_count", 128'(exp_err.size()), 1);
        run_test("t4_limit", 0, aw, re, fa);
        chk("t4_err_pulses", 128'(err_pulses), 1);

        // Exactly reaching the limit is not a truncation.
        sw_olimit = 24'd24;
        clear_src();
        add_frame(1, 6, 3, 8);
        build_model(1, 24);
        chk("t5_model_no_err", {128'(exp_err.size()), exp_q[2].last, exp_q[2].err}, {128'(0), 2'b10});
        run_test("t5_exact", 0, aw, re, fa);
        chk("t5_err_pulses", 128'(err_pulses), 0);

        // Reset after the first beat of a 3-beat frame.
        sw_olimit_en = 0;
        do_reset();
        ifc.in_data[0 +: DW] = pat(0, 7, 0);
        ifc.in_bytes[0 +: BW] = 4'd8;
        ifc.in_last = '0;
        ifc.in_valid = 2'b01;
        w = 0;
        @(negedge clk);
        while (!ifc.in_ready[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("t6_first_accept", 128'(ifc.in_ready[0]), 1);
        @(posedge clk);
        #1 rst = 1;
        ifc.in_valid = '0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_valid_busy", {ifc.out_valid, busy, ifc.in_ready, olimit_err}, 0);
        chk("t6_rst_fields", {ifc.out_data, ifc.out_bytes, ifc.out_last, ifc.out_err, ifc.out_ch, olimit_err_ch}, 0);
        @(posedge clk);
        #1 rst = 0;
        model_rr = 0;
        exp_q.delete();
        exp_err.delete();
        clear_src();
        @(negedge clk);
        chk("t6_idle_after_release", {busy, ifc.out_valid}, 0);
        @(posedge clk);
        #1;
        add_frame(1, 8, 2, 8);
        build_model(0, 0);
        run_test("t6_after_rst", 0, aw, re, fa);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
